// File: rtl/saw_interp_xfade_pkg.sv
// Shared types and defaults for the sawtooth interpolate/crossfade stage.
package saw_interp_xfade_pkg;

  localparam int FRAC_W_DEF = 8;
  localparam int SAMPLE_W   = 16;

  typedef logic signed [SAMPLE_W-1:0] sample_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_CAPTURE,
    ST_MUL0,
    ST_MUL1,
    ST_MUL2
  } interp_state_t;

endpackage

// File: rtl/saw_interp_xfade_lerp_mul.sv
// Shared combinational lerp datapath: y = a + floor((b - a) * w / 2^FRAC_W).
module saw_interp_xfade_lerp_mul
  import saw_interp_xfade_pkg::*;
#(
  parameter int FRAC_W = FRAC_W_DEF
) (
  input  sample_t           a_i,
  input  sample_t           b_i,
  input  logic [FRAC_W-1:0] w_i,
  output sample_t           y_o
);

  localparam int PROD_W = SAMPLE_W + FRAC_W + 2;

  logic signed [SAMPLE_W:0]   diff;
  logic signed [FRAC_W:0]     w_ext;
  logic signed [PROD_W-1:0]   prod;
  logic signed [PROD_W-1:0]   step;
  logic signed [PROD_W-1:0]   sum;
  logic                       sum_hi_unused;

  // 17-bit signed difference times a zero-extended (always positive) weight.
  assign diff  = {b_i[SAMPLE_W-1], b_i} - {a_i[SAMPLE_W-1], a_i};
  assign w_ext = {1'b0, w_i};
  assign prod  = PROD_W'(diff) * PROD_W'(w_ext);

  // Arithmetic shift floors toward -inf, so a negative step rounds away from a.
  assign step = prod >>> FRAC_W;
  assign sum  = PROD_W'(a_i) + step;

  // The result always lies between a and b, so the upper bits carry no
  // information and the 16-bit truncation is exact.
  assign y_o           = sum[SAMPLE_W-1:0];
  assign sum_hi_unused = ^sum[PROD_W-1:SAMPLE_W];

endmodule

// File: rtl/saw_interp_xfade.sv
// Two-bank wavetable interpolator with octave crossfade, one shared multiplier.
//
// state    | meaning
// ---------+---------------------------------------------------------
// IDLE     | waiting for start; romRdEn follows start
// WAIT     | ROM read in flight, counting down the read latency
// CAPTURE  | ROM data valid; register both banks at A and A+1
// MUL0     | bank 0 lerp by fractional phase -> i0
// MUL1     | bank 1 lerp by fractional phase -> i1
// MUL2     | crossfade i0 -> i1 by xfade -> sampleOut, pulse sampleValid
module saw_interp_xfade
  import saw_interp_xfade_pkg::*;
#(
  parameter int ROM_LAT = 2,
  parameter int FRAC_W  = FRAC_W_DEF
) (
  input  logic                   Clk,
  input  logic                   Reset_n,
  input  logic                   start,
  input  logic [FRAC_W-1:0]      fracPhase,
  input  logic [FRAC_W-1:0]      xfade,
  output logic                   romRdEn,
  input  logic [1:0][15:0]       interpIn,
  input  logic [1:0][15:0]       antiInterpIn,
  output logic                   busy,
  output logic signed [15:0]     sampleOut,
  output logic                   sampleValid
);

  localparam int CNT_W = (ROM_LAT > 2) ? $clog2(ROM_LAT) : 1;

  interp_state_t     state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [FRAC_W-1:0] frac_q;
  logic [FRAC_W-1:0] xf_q;
  sample_t           a0_q, b0_q, a1_q, b1_q;
  sample_t           i0_q, i1_q;

  sample_t           mul_a, mul_b, mul_y;
  logic [FRAC_W-1:0] mul_w;

  assign romRdEn = start && (state_q == ST_IDLE);
  assign busy    = (state_q != ST_IDLE);

  // Operand select for the single multiplier, steered by the current multiply step.
  always_comb begin
    mul_a = a0_q;
    mul_b = b0_q;
    mul_w = frac_q;
    case (state_q)
      ST_MUL1: begin
        mul_a = a1_q;
        mul_b = b1_q;
      end
      ST_MUL2: begin
        mul_a = i0_q;
        mul_b = i1_q;
        mul_w = xf_q;
      end
      default: ;
    endcase
  end

  saw_interp_xfade_lerp_mul #(.FRAC_W(FRAC_W)) u_lerp (
    .a_i (mul_a),
    .b_i (mul_b),
    .w_i (mul_w),
    .y_o (mul_y)
  );

  // Request sequencer: latency count, capture, three multiply steps, output register.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      frac_q      <= '0;
      xf_q        <= '0;
      a0_q        <= '0;
      b0_q        <= '0;
      a1_q        <= '0;
      b1_q        <= '0;
      i0_q        <= '0;
      i1_q        <= '0;
      sampleOut   <= '0;
      sampleValid <= 1'b0;
    end else begin
      sampleValid <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            frac_q  <= fracPhase;
            xf_q    <= xfade;
            cnt_q   <= CNT_W'(ROM_LAT - 1);
            state_q <= (ROM_LAT > 1) ? ST_WAIT : ST_CAPTURE;
          end
        end
        ST_WAIT: begin
          // Leaving when the count would reach zero puts CAPTURE exactly
          // ROM_LAT cycles after the start cycle.
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q <= CNT_W'(1)) begin
            state_q <= ST_CAPTURE;
          end
        end
        ST_CAPTURE: begin
          a0_q    <= interpIn[0];
          b0_q    <= antiInterpIn[0];
          a1_q    <= interpIn[1];
          b1_q    <= antiInterpIn[1];
          state_q <= ST_MUL0;
        end
        ST_MUL0: begin
          i0_q    <= mul_y;
          state_q <= ST_MUL1;
        end
        ST_MUL1: begin
          i1_q    <= mul_y;
          state_q <= ST_MUL2;
        end
        ST_MUL2: begin
          sampleOut   <= mul_y;
          sampleValid <= 1'b1;
          state_q     <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_saw_interp_xfade.sv
// Randomized self-checking bench for saw_interp_xfade against an arithmetic model.
module tb_saw_interp_xfade;

  localparam int ROM_LAT = 2;
  localparam int FRAC_W  = 8;
  localparam int LAT     = ROM_LAT + 4;

  logic                 Clk = 1'b0;
  logic                 Reset_n;
  logic                 start;
  logic [FRAC_W-1:0]    fracPhase;
  logic [FRAC_W-1:0]    xfade;
  logic                 romRdEn;
  logic [1:0][15:0]     interpIn;
  logic [1:0][15:0]     antiInterpIn;
  logic                 busy;
  logic signed [15:0]   sampleOut;
  logic                 sampleValid;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 Clk = ~Clk;

  saw_interp_xfade #(.ROM_LAT(ROM_LAT), .FRAC_W(FRAC_W)) dut (
    .Clk          (Clk),
    .Reset_n      (Reset_n),
    .start        (start),
    .fracPhase    (fracPhase),
    .xfade        (xfade),
    .romRdEn      (romRdEn),
    .interpIn     (interpIn),
    .antiInterpIn (antiInterpIn),
    .busy         (busy),
    .sampleOut    (sampleOut),
    .sampleValid  (sampleValid)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // a + floor((b - a) * w / 256), using plain integer division with an explicit floor fix-up.
  function automatic int lerp_ref(input int a, input int b, input int w);
    int p;
    int q;
    p = (b - a) * w;
    q = p / (1 << FRAC_W);
    if ((p < 0) && ((p % (1 << FRAC_W)) != 0)) q = q - 1;
    return a + q;
  endfunction

  function automatic int rnd_sample();
    return int'($urandom_range(0, 65535)) - 32768;
  endfunction

  task automatic scramble();
    interpIn[0]     = 16'($urandom);
    interpIn[1]     = 16'($urandom);
    antiInterpIn[0] = 16'($urandom);
    antiInterpIn[1] = 16'($urandom);
    fracPhase       = 8'($urandom);
    xfade           = 8'($urandom);
  endtask

  // One request; ROM data is only valid in the CAPTURE cycle, weights only in the start cycle.
  task automatic request(input int a0, input int b0, input int a1, input int b1,
                         input int fr, input int xf, input int ex);
    @(negedge Clk);
    scramble();
    start     = 1'b1;
    fracPhase = 8'(fr);
    xfade     = 8'(xf);
    #1 chk("rden_start", romRdEn, 1);
    for (int c = 1; c <= LAT; c++) begin
      @(negedge Clk);
      scramble();
      start = (c < LAT) ? 1'($urandom_range(0, 1)) : 1'b0;
      if (c == ROM_LAT) begin
        interpIn[0]     = 16'(a0);
        antiInterpIn[0] = 16'(b0);
        interpIn[1]     = 16'(a1);
        antiInterpIn[1] = 16'(b1);
      end
      #1;
      if (c < LAT) begin
        chk("busy", busy, 1);
        chk("valid_early", sampleValid, 0);
        chk("rden_busy", romRdEn, 0);
      end else begin
        chk("valid", sampleValid, 1);
        chk("busy_done", busy, 0);
        chk("sample", sampleOut, ex);
      end
    end
    @(negedge Clk);
    #1 chk("valid_pulse", sampleValid, 0);
  endtask

  initial begin
    int a0, b0, a1, b1, fr, xf, ex, nvalid;

    Reset_n = 1'b0;
    start   = 1'b0;
    scramble();
    repeat (3) @(negedge Clk);
    #1;
    chk("rst_sample", sampleOut, 0);
    chk("rst_valid", sampleValid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rden", romRdEn, 0);
    @(negedge Clk);
    Reset_n = 1'b1;

    // Directed corner cases.
    request(1000, 2000, 1000, 2000, 128, 0, 1500);
    request(0, -1, 0, 0, 128, 0, -1);
    request(32767, -32768, 0, 0, 255, 0, -32513);
    request(1000, 2000, -500, -500, 128, 64, 1000);
    request(-1234, 5678, 0, 0, 0, 0, -1234);
    request(0, 256, 0, 0, 255, 0, 255);
    request(-32768, 32767, 32767, -32768, 255, 255, -32259);

    // Random requests against the model.
    for (int k = 0; k < 24; k++) begin
      a0 = rnd_sample();
      b0 = rnd_sample();
      a1 = rnd_sample();
      b1 = rnd_sample();
      fr = int'($urandom_range(0, 255));
      xf = int'($urandom_range(0, 255));
      ex = lerp_ref(lerp_ref(a0, b0, fr), lerp_ref(a1, b1, fr), xf);
      request(a0, b0, a1, b1, fr, xf, ex);
    end

    // start held high: a new request is accepted in every sampleValid cycle.
    a0 = -1200; b0 = 3000; a1 = 500; b1 = -700; fr = 77; xf = 200;
    ex = lerp_ref(lerp_ref(a0, b0, fr), lerp_ref(a1, b1, fr), xf);
    interpIn[0]     = 16'(a0);
    antiInterpIn[0] = 16'(b0);
    interpIn[1]     = 16'(a1);
    antiInterpIn[1] = 16'(b1);
    fracPhase       = 8'(fr);
    xfade           = 8'(xf);
    nvalid          = 0;
    for (int c = 0; c < 6 * LAT; c++) begin
      @(negedge Clk);
      start = 1'b1;
      #1;
      chk("b2b_rden", romRdEn, int'((c % LAT) == 0));
      chk("b2b_valid", sampleValid, int'(((c % LAT) == 0) && (c > 0)));
      if (sampleValid) begin
        nvalid++;
        chk("b2b_sample", sampleOut, ex);
      end
    end
    for (int c = 0; c <= LAT; c++) begin
      @(negedge Clk);
      start = 1'b0;
      #1;
      if (sampleValid) nvalid++;
    end
    chk("b2b_count", nvalid, 6);

    // Reset in MUL0 aborts the request silently.
    request(1000, 2000, 1000, 2000, 128, 0, 1500);
    @(negedge Clk);
    start = 1'b1;
    interpIn[0]     = 16'(100);
    antiInterpIn[0] = 16'(200);
    @(negedge Clk);
    start = 1'b0;
    @(negedge Clk);
    @(negedge Clk);
    Reset_n = 1'b0;
    #1;
    chk("abort_sample", sampleOut, 0);
    chk("abort_busy", busy, 0);
    chk("abort_valid", sampleValid, 0);
    @(negedge Clk);
    Reset_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge Clk);
      #1;
      chk("abort_no_valid", sampleValid, 0);
      chk("abort_idle", busy, 0);
    end
    request(0, 256, 0, 0, 255, 0, 255);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
